// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter: fetch and data requesters take turns on one
// memory port, one access in flight. IDLE samples requests, BUSY drives the
// memory for MEM_LAT cycles, DONE pulses the owner's ack for one cycle.
module mem_arbiter #(
   parameter int unsigned INSTR_SIZE = 32,
   parameter int unsigned MEM_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  f_req,
   input  logic [INSTR_SIZE-1:0] f_addr,
   input  logic                  f_kill,
   output logic                  f_ack,
   output logic [INSTR_SIZE-1:0] f_rdata,
   input  logic                  d_req,
   input  logic                  d_wr,
   input  logic [INSTR_SIZE-1:0] d_addr,
   input  logic [INSTR_SIZE-1:0] d_wdata,
   output logic                  d_ack,
   output logic [INSTR_SIZE-1:0] d_rdata,
   output logic [INSTR_SIZE-1:0] mem_addr,
   output logic                  mem_rd_wr,
   output logic                  mem_op_en,
   output logic [INSTR_SIZE-1:0] mem_wr_data,
   input  logic [INSTR_SIZE-1:0] mem_rd_data
);

   // addi x0, x0, 0 -- fetch data seen before the first real fetch
   localparam logic [INSTR_SIZE-1:0] NOP_INSTR = INSTR_SIZE'(32'h0000_0013);
   localparam logic [3:0]            LAT_LOAD  = 4'(MEM_LAT - 1);
   localparam logic                  OWN_FETCH = 1'b0;
   localparam logic                  OWN_DATA  = 1'b1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q, owner_d;
   logic                  kill_q, kill_d;
   logic                  wr_q, wr_d;
   logic [INSTR_SIZE-1:0] addr_q, addr_d;
   logic [INSTR_SIZE-1:0] wdata_q, wdata_d;
   logic [INSTR_SIZE-1:0] f_rdata_q, f_rdata_d;
   logic [INSTR_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                  grant_data;

   // Next-state, grant decision and output decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      kill_d       = kill_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      f_rdata_d    = f_rdata_q;
      d_rdata_d    = d_rdata_q;
      grant_data   = 1'b0;

      unique case (state_q)
         StIdle: begin
            kill_d = 1'b0;
            if (f_req || d_req) begin
               // On conflict the side not served last wins
               grant_data   = d_req && (!f_req || (last_grant_q == OWN_FETCH));
               owner_d      = grant_data;
               last_grant_d = grant_data;
               addr_d       = grant_data ? d_addr : f_addr;
               wr_d         = grant_data && d_wr;
               if (grant_data) begin
                  wdata_d = d_wdata;
               end
               cnt_d   = LAT_LOAD;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if ((owner_q == OWN_FETCH) && f_kill) begin
               kill_d = 1'b1;
            end
            if (cnt_q == 4'd0) begin
               state_d = StDone;
               if (!wr_q) begin
                  if (owner_q == OWN_DATA) begin
                     d_rdata_d = mem_rd_data;
                  end else begin
                     f_rdata_d = mem_rd_data;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            kill_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A kill arriving in the DONE cycle itself still suppresses that ack
      f_ack       = (state_q == StDone) && (owner_q == OWN_FETCH) && !kill_q && !f_kill;
      d_ack       = (state_q == StDone) && (owner_q == OWN_DATA);
      mem_op_en   = (state_q == StBusy);
      mem_rd_wr   = (state_q == StBusy) && wr_q;
      mem_addr    = addr_q;
      mem_wr_data = wdata_q;
      f_rdata     = f_rdata_q;
      d_rdata     = d_rdata_q;
   end

   // State registers; reset abandons any access in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         last_grant_q <= OWN_FETCH;
         owner_q      <= OWN_FETCH;
         kill_q       <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         f_rdata_q    <= NOP_INSTR;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         kill_q       <= kill_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         f_rdata_q    <= f_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected acks plus
// per-scenario inline checks; extra instances cover MEM_LAT = 1 and 15.
module tb_mem_arbiter;

   localparam int unsigned W = 32;

   typedef struct packed {
      logic         is_data;
      logic [W-1:0] rdata;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         f_req = 1'b0, f_kill = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [W-1:0] f_addr = '0, d_addr = '0, d_wdata = '0;
   logic         f_ack, d_ack, mem_rd_wr, mem_op_en;
   logic [W-1:0] f_rdata, d_rdata, mem_addr, mem_wr_data, mem_rd_data;

   // Latency sweep instances (index 0: MEM_LAT=1, index 1: MEM_LAT=15)
   logic [1:0]   s_f_req = 2'b00;
   logic [W-1:0] s_f_addr = '0;
   logic [1:0]   s_f_ack, s_d_ack, s_rd_wr, s_op_en;
   logic [W-1:0] s_f_rdata [2];
   logic [W-1:0] s_d_rdata [2];
   logic [W-1:0] s_mem_addr [2];
   logic [W-1:0] s_wr_data [2];
   logic [W-1:0] s_rd_data [2];

   exp_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] d_rdata_model = '0;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mem_model(input logic [W-1:0] a);
      if (a == 32'h100) return 32'h00A0_0093;
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   assign mem_rd_data  = mem_model(mem_addr);
   assign s_rd_data[0] = mem_model(s_mem_addr[0]);
   assign s_rd_data[1] = mem_model(s_mem_addr[1]);

   mem_arbiter #(.INSTR_SIZE(W), .MEM_LAT(2)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill), .f_ack(f_ack), .f_rdata(f_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr), .mem_op_en(mem_op_en),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   mem_arbiter #(.INSTR_SIZE(W), .MEM_LAT(1)) u_lat1 (
      .clk(clk), .reset_n(reset_n),
      .f_req(s_f_req[0]), .f_addr(s_f_addr), .f_kill(1'b0), .f_ack(s_f_ack[0]),
      .f_rdata(s_f_rdata[0]),
      .d_req(1'b0), .d_wr(1'b0), .d_addr('0), .d_wdata('0),
      .d_ack(s_d_ack[0]), .d_rdata(s_d_rdata[0]),
      .mem_addr(s_mem_addr[0]), .mem_rd_wr(s_rd_wr[0]), .mem_op_en(s_op_en[0]),
      .mem_wr_data(s_wr_data[0]), .mem_rd_data(s_rd_data[0])
   );

   mem_arbiter #(.INSTR_SIZE(W), .MEM_LAT(15)) u_lat15 (
      .clk(clk), .reset_n(reset_n),
      .f_req(s_f_req[1]), .f_addr(s_f_addr), .f_kill(1'b0), .f_ack(s_f_ack[1]),
      .f_rdata(s_f_rdata[1]),
      .d_req(1'b0), .d_wr(1'b0), .d_addr('0), .d_wdata('0),
      .d_ack(s_d_ack[1]), .d_rdata(s_d_rdata[1]),
      .mem_addr(s_mem_addr[1]), .mem_rd_wr(s_rd_wr[1]), .mem_op_en(s_op_en[1]),
      .mem_wr_data(s_wr_data[1]), .mem_rd_data(s_rd_data[1])
   );

   // Scoreboard: every ack on the main instance must match the oldest expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset_n && (f_ack || d_ack)) begin
         checks++;
         if (f_ack && d_ack) begin
            errors++;
            $display("FAIL ack_overlap f_ack=%0b d_ack=%0b want only one", f_ack, d_ack);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack f_ack=%0b d_ack=%0b want no ack", f_ack, d_ack);
         end else begin
            e = exp_q.pop_front();
            if (d_ack !== e.is_data || (e.is_data ? d_rdata : f_rdata) !== e.rdata) begin
               errors++;
               $display("FAIL sb_ack got is_data=%0b rdata=%h want is_data=%0b rdata=%h",
                        d_ack, e.is_data ? d_rdata : f_rdata, e.is_data, e.rdata);
            end
         end
      end
   end

   // Drive one access on the main instance and observe it for max_k cycles
   task automatic access(input logic is_data, input logic wr, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata, input logic kill_it, input int max_k,
                         output int busy, output int lat, output logic [W-1:0] first_addr,
                         output logic first_rd_wr, output logic [W-1:0] first_wdata);
      busy = 0;
      lat = 0;
      first_addr = '0;
      first_rd_wr = 1'b0;
      first_wdata = '0;
      @(posedge clk); #1;
      if (is_data) begin
         d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
      end else begin
         f_req = 1'b1; f_addr = addr;
      end
      for (int k = 1; k <= max_k; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            first_addr = mem_addr; first_rd_wr = mem_rd_wr; first_wdata = mem_wr_data;
         end
         if (mem_op_en) busy++;
         f_kill = kill_it && (k == 1);
         if (kill_it && k == 1) f_req = 1'b0;
         if (lat == 0 && (is_data ? d_ack : f_ack)) begin
            lat = k;
            if (is_data) d_req = 1'b0;
            else f_req = 1'b0;
         end
      end
      f_kill = 1'b0; f_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [W-1:0] obs [8];
      logic [W-1:0] want [8];
      #1 reset_n = 1'b0;
      #12;
      obs  = '{W'(f_ack), W'(d_ack), W'(mem_op_en), W'(mem_rd_wr), mem_addr, mem_wr_data,
               f_rdata, d_rdata};
      want = '{0, 0, 0, 0, 0, 0, 32'h13, 0};
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (obs[i] !== want[i]) begin
            errors++;
            $display("FAIL reset_val[%0d] got %h want %h", i, obs[i], want[i]);
         end
      end
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic test_arbitration();
      int acks = 0;
      int ack_k [4];
      logic [3:0] order = '0;
      d_rdata_model = mem_model(32'h200);
      exp_q.push_back('{1'b1, mem_model(32'h200)});
      exp_q.push_back('{1'b0, mem_model(32'h10C)});
      exp_q.push_back('{1'b1, mem_model(32'h200)});
      exp_q.push_back('{1'b0, mem_model(32'h10C)});
      @(posedge clk); #1;
      f_req = 1'b1; f_addr = 32'h10C;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if ((f_ack || d_ack) && acks < 4) begin
            order[3-acks] = d_ack;
            ack_k[acks] = k;
            acks++;
            if (acks == 4) begin f_req = 1'b0; d_req = 1'b0; end
         end
      end
      f_req = 1'b0; d_req = 1'b0;
      checks++;
      if (acks != 4) begin
         errors++; $display("FAIL arb_ack_count got %0d want 4", acks);
      end
      checks++;
      if (order !== 4'b1010) begin
         errors++; $display("FAIL arb_order got %b want 1010 (D,F,D,F)", order);
      end
      checks++;
      if (acks == 4 && (ack_k[0] != 3 || ack_k[3] != 15)) begin
         errors++;
         $display("FAIL arb_spacing got first=%0d last=%0d want 3 15", ack_k[0], ack_k[3]);
      end
   endtask

   task automatic test_fetch();
      int busy, lat;
      logic [W-1:0] fa, fw;
      logic frw;
      exp_q.push_back('{1'b0, 32'h00A0_0093});
      access(1'b0, 1'b0, 32'h100, '0, 1'b0, 6, busy, lat, fa, frw, fw);
      checks++;
      if (busy != 2) begin errors++; $display("FAIL fetch_busy got %0d want 2", busy); end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL fetch_lat got %0d want 3", lat); end
      checks++;
      if (fa !== 32'h100 || frw !== 1'b0) begin
         errors++; $display("FAIL fetch_mem got addr=%h rd_wr=%b want 100 0", fa, frw);
      end
   endtask

   task automatic test_store();
      int busy, lat;
      logic [W-1:0] fa, fw;
      logic frw;
      exp_q.push_back('{1'b1, d_rdata_model});
      access(1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 1'b0, 6, busy, lat, fa, frw, fw);
      checks++;
      if (frw !== 1'b1 || fw !== 32'hDEAD_BEEF || fa !== 32'h300) begin
         errors++;
         $display("FAIL store_mem got rd_wr=%b wdata=%h addr=%h want 1 deadbeef 300",
                  frw, fw, fa);
      end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL store_lat got %0d want 3", lat); end
      checks++;
      if (d_rdata !== d_rdata_model) begin
         errors++; $display("FAIL store_rdata got %h want %h", d_rdata, d_rdata_model);
      end
   endtask

   task automatic test_kill();
      int busy, lat;
      logic [W-1:0] fa, fw;
      logic frw;
      access(1'b0, 1'b0, 32'h104, '0, 1'b1, 8, busy, lat, fa, frw, fw);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL kill_ack got lat=%0d want no ack", lat); end
      checks++;
      if (busy != 2) begin errors++; $display("FAIL kill_busy got %0d want 2", busy); end
      exp_q.push_back('{1'b0, mem_model(32'h200)});
      access(1'b0, 1'b0, 32'h200, '0, 1'b0, 6, busy, lat, fa, frw, fw);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL kill_next_lat got %0d want 3", lat); end
   endtask

   task automatic test_reset_mid();
      int busy, lat;
      logic [W-1:0] fa, fw;
      logic frw;
      logic [W-1:0] obs [6];
      logic [W-1:0] want [6];
      @(posedge clk); #1;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h3F0;
      @(posedge clk); #1;
      checks++;
      if (mem_op_en !== 1'b1) begin
         errors++; $display("FAIL rmid_busy got %b want 1", mem_op_en);
      end
      #2 reset_n = 1'b0; d_req = 1'b0;
      #1;
      d_rdata_model = '0;
      obs  = '{W'(d_ack), W'(mem_op_en), W'(mem_rd_wr), mem_addr, f_rdata, d_rdata};
      want = '{0, 0, 0, 0, 32'h13, 0};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (obs[i] !== want[i]) begin
            errors++;
            $display("FAIL rmid_val[%0d] got %h want %h", i, obs[i], want[i]);
         end
      end
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (6) @(posedge clk);
      exp_q.push_back('{1'b0, mem_model(32'h108)});
      access(1'b0, 1'b0, 32'h108, '0, 1'b0, 6, busy, lat, fa, frw, fw);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL rmid_fresh_lat got %0d want 3", lat); end
   endtask

   task automatic test_latency_sweep();
      int lat_cfg [2] = '{1, 15};
      for (int idx = 0; idx < 2; idx++) begin
         int busy = 0;
         int lat = 0;
         logic [W-1:0] rd = '0;
         @(posedge clk); #1;
         s_f_addr = 32'h140 + 32'(idx * 4);
         s_f_req[idx] = 1'b1;
         for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (s_op_en[idx]) busy++;
            if (lat == 0 && s_f_ack[idx]) begin
               lat = k; rd = s_f_rdata[idx]; s_f_req[idx] = 1'b0;
            end
         end
         s_f_req[idx] = 1'b0;
         checks++;
         if (busy != lat_cfg[idx]) begin
            errors++; $display("FAIL sweep_busy L=%0d got %0d", lat_cfg[idx], busy);
         end
         checks++;
         if (lat != lat_cfg[idx] + 1) begin
            errors++;
            $display("FAIL sweep_lat L=%0d got %0d want %0d", lat_cfg[idx], lat,
                     lat_cfg[idx] + 1);
         end
         checks++;
         if (rd !== mem_model(s_f_addr)) begin
            errors++; $display("FAIL sweep_rdata got %h want %h", rd, mem_model(s_f_addr));
         end
         checks++;
         if (s_d_ack[idx] !== 1'b0 || s_rd_wr[idx] !== 1'b0 || s_d_rdata[idx] !== '0 ||
             s_wr_data[idx] !== '0) begin
            errors++;
            $display("FAIL sweep_idle got d_ack=%b rd_wr=%b d_rdata=%h wr_data=%h want 0s",
                     s_d_ack[idx], s_rd_wr[idx], s_d_rdata[idx], s_wr_data[idx]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_fetch();
      test_store();
      test_kill();
      test_reset_mid();
      test_latency_sweep();
      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
